// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, next-PC select, IF/ID pipeline register.
// Latency: one cycle from PC to instr_d; a redirect sampled at edge N sets pc after N.
// Backpressure: stall freezes pc and IF/ID; exc_req/eret still redirect and flush.
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   stall                      hazard stall from decode
//   br_take, br_target         taken branch/jump redirect from decode
//   exc_req                    CP0 exception/interrupt, redirect to HANDLER_PC
//   eret, epc                  exception return, redirect to epc
//   instr                      combinational instruction memory data for pc
//   pc                         fetch address to instruction memory
//   instr_d, pc_d, pc8_d       IF/ID instruction, PC and link address (pc_d + 8)
//   valid_d, adel_d            IF/ID holds a real instruction / fetch address error
//
// Build option: define BRANCH_DELAY_SLOT_EN to keep the instruction fetched in
// the branch-redirect cycle (delay slot). When undefined, a taken branch
// flushes IF/ID, giving a one-bubble penalty.

module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int unsigned IM_WORDS   = 2048,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_take,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        valid_d,
  output logic        adel_d
);

  // Highest word address backed by instruction memory.
  localparam logic [31:0] LAST_PC = RESET_PC + 32'(IM_WORDS * 4) - 32'd4;

  logic        addr_err;
  logic        flush;
  logic        br_flush;
  logic [31:0] pc_next;

`ifdef BRANCH_DELAY_SLOT_EN
  assign br_flush = 1'b0;
`else
  // A branch that decode is still stalling on is not final, so it cannot flush.
  assign br_flush = br_take & ~stall;
`endif

  always_comb begin
    addr_err = (pc[1:0] != 2'b00) || (pc < RESET_PC) || (pc > LAST_PC);
    flush    = exc_req | eret;

    // exc_req and eret outrank stall; br_take only acts on an unstalled cycle.
    pc_next = pc + 32'd4;
    if (exc_req)
      pc_next = HANDLER_PC;
    else if (eret)
      pc_next = epc;
    else if (stall)
      pc_next = pc;
    else if (br_take)
      pc_next = br_target;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      instr_d <= 32'h0;
      pc_d    <= 32'h0;
      valid_d <= 1'b0;
      adel_d  <= 1'b0;
    end else begin
      pc <= pc_next;
      if (flush || br_flush) begin
        // Bubble still carries pc so the slot is traceable in decode.
        instr_d <= 32'h0;
        pc_d    <= pc;
        valid_d <= 1'b0;
        adel_d  <= 1'b0;
      end else if (!stall) begin
        // A bad fetch becomes a valid NOP-like slot carrying the faulting PC,
        // so CP0 can raise a precise AdEL when it reaches decode.
        instr_d <= addr_err ? 32'h0 : instr;
        pc_d    <= pc;
        valid_d <= 1'b1;
        adel_d  <= addr_err;
      end
    end
  end

  assign pc8_d = pc_d + 32'd8;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam int          IM_WORDS   = 2048;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, br_take, exc_req, eret;
  logic [31:0] br_target, epc, instr;
  logic [31:0] pc, instr_d, pc_d, pc8_d;
  logic        valid_d, adel_d;

  int checks = 0;
  int failures = 0;

  // Reference state: the fetch address and the IF/ID contents.
  logic [31:0] m_pc, m_instr_d, m_pc_d;
  logic        m_valid, m_adel;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .IM_WORDS(IM_WORDS), .HANDLER_PC(HANDLER_PC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_take(br_take), .br_target(br_target),
    .exc_req(exc_req), .eret(eret), .epc(epc), .instr(instr), .pc(pc),
    .instr_d(instr_d), .pc_d(pc_d), .pc8_d(pc8_d), .valid_d(valid_d), .adel_d(adel_d)
  );

  // Instruction memory contents: a distinct non-zero word for every address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign instr = mem_word(pc);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge of the fetch stage, described from its rules.
  task automatic model_edge(input logic r, s, bt, input logic [31:0] bta,
                            input logic ex, er, input logic [31:0] ep);
    longint off;
    bit     bad, kill;
    if (r) begin
      m_pc = RESET_PC; m_instr_d = 0; m_pc_d = 0; m_valid = 0; m_adel = 0;
      return;
    end
    off  = longint'(m_pc) - longint'(RESET_PC);
    bad  = (off < 0) || (off % 4 != 0) || (off >= 4 * IM_WORDS);
    kill = ex || er || (bt && !s && !DS);
    if (kill) begin
      m_instr_d = 0; m_valid = 0; m_adel = 0; m_pc_d = m_pc;
    end else if (!s) begin
      m_pc_d = m_pc; m_valid = 1; m_adel = bad;
      m_instr_d = bad ? 32'h0 : mem_word(m_pc);
    end
    if (ex)        m_pc = HANDLER_PC;
    else if (er)   m_pc = ep;
    else if (!s)   m_pc = bt ? bta : m_pc + 32'd4;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".pc"},      pc,                m_pc);
    chk({tag, ".instr_d"}, instr_d,           m_instr_d);
    chk({tag, ".pc_d"},    pc_d,              m_pc_d);
    chk({tag, ".pc8_d"},   pc8_d,             m_pc_d + 32'd8);
    chk({tag, ".valid_d"}, {31'b0, valid_d},  {31'b0, m_valid});
    chk({tag, ".adel_d"},  {31'b0, adel_d},   {31'b0, m_adel});
  endtask

  // Drive inputs mid-cycle, advance one edge, then compare against the model.
  task automatic step(input string tag, input logic r, s, bt, input logic [31:0] bta,
                      input logic ex, er, input logic [31:0] ep);
    reset = r; stall = s; br_take = bt; br_target = bta;
    exc_req = ex; eret = er; epc = ep;
    model_edge(r, s, bt, bta, ex, er, ep);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 32'h0, 0, 0, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = RESET_PC + 32'(4 * $urandom_range(0, IM_WORDS - 1));
    case ($urandom_range(0, 4))
      0, 1: rand_addr = a;
      2:    rand_addr = a + 32'($urandom_range(1, 3));
      3:    rand_addr = $urandom();
      default: begin
        case ($urandom_range(0, 3))
          0: rand_addr = RESET_PC - 32'd4;
          1: rand_addr = RESET_PC + 32'(4 * IM_WORDS) - 32'd4;
          2: rand_addr = RESET_PC + 32'(4 * IM_WORDS);
          default: rand_addr = 32'hFFFF_FFFC;
        endcase
      end
    endcase
  endfunction

  initial begin
    reset = 1; stall = 0; br_take = 0; br_target = 0;
    exc_req = 0; eret = 0; epc = 0;
    #2;

    // Reset state
    step("rst", 1, 0, 0, 32'h0, 0, 0, 32'h0);
    step("rst", 1, 0, 0, 32'h0, 0, 0, 32'h0);
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_pc8", pc8_d, 32'd8);
    chk("rst_valid", {31'b0, valid_d}, 32'd0);

    // Three free-running fetches
    idle("run", 3);
    chk("run_pc", pc, 32'h0000_300C);
    chk("run_instr", instr_d, mem_word(32'h0000_3008));
    chk("run_pcd", pc_d, 32'h0000_3008);
    chk("run_pc8", pc8_d, 32'h0000_3010);
    chk("run_valid", {31'b0, valid_d}, 32'd1);

    // Stall holds pc and IF/ID
    idle("run", 1);
    step("stall", 0, 1, 0, 32'h0, 0, 0, 32'h0);
    step("stall", 0, 1, 1, 32'h0000_3200, 0, 0, 32'h0);
    chk("stall_pc", pc, 32'h0000_3010);
    chk("stall_instr", instr_d, mem_word(32'h0000_300C));
    idle("release", 1);
    chk("release_pc", pc, 32'h0000_3014);

    // Taken branch at 0x3008
    step("rst2", 1, 0, 0, 32'h0, 0, 0, 32'h0);
    idle("run2", 2);
    step("br", 0, 0, 1, 32'h0000_3100, 0, 0, 32'h0);
    chk("br_pc", pc, 32'h0000_3100);
    chk("br_valid", {31'b0, valid_d}, DS ? 32'd1 : 32'd0);
    chk("br_instr", instr_d, DS ? mem_word(32'h0000_3008) : 32'h0);

    // Exception beats stall and branch
    step("exc", 0, 1, 1, 32'h0000_3300, 1, 0, 32'h0);
    chk("exc_pc", pc, 32'h0000_4180);
    chk("exc_valid", {31'b0, valid_d}, 32'd0);
    idle("exc_fetch", 1);
    chk("exc_instr", instr_d, mem_word(32'h0000_4180));

    // eret to a misaligned epc, then a branch outside memory
    step("eret", 0, 0, 0, 32'h0, 0, 1, 32'h0000_3002);
    chk("eret_pc", pc, 32'h0000_3002);
    idle("eret_fetch", 1);
    chk("eret_adel", {31'b0, adel_d}, 32'd1);
    chk("eret_instr", instr_d, 32'h0);
    chk("eret_pcd", pc_d, 32'h0000_3002);
    step("oor_br", 0, 0, 1, 32'h0000_5000, 0, 0, 32'h0);
    idle("oor_fetch", 1);
    chk("oor_adel", {31'b0, adel_d}, 32'd1);
    chk("oor_pcd", pc_d, 32'h0000_5000);

    // exc_req and eret together: exception wins
    step("exc_eret", 0, 0, 0, 32'h0, 1, 1, 32'h0000_3040);
    chk("exc_eret_pc", pc, 32'h0000_4180);

    // Wrap of pc+4 past the top of the address space
    step("wrap", 0, 0, 0, 32'h0, 0, 1, 32'hFFFF_FFFC);
    idle("wrap", 2);
    chk("wrap_pcd", pc_d, 32'h0);

    // Reset overrides an eret in flight
    step("rst3", 1, 0, 0, 32'h0, 0, 0, 32'h0);
    idle("run3", 16);
    chk("run3_pc", pc, 32'h0000_3040);
    step("rst_eret", 1, 0, 0, 32'h0, 0, 1, 32'h0000_3500);
    chk("rst_eret_pc", pc, 32'h0000_3000);
    chk("rst_eret_pcd", pc_d, 32'h0);
    chk("rst_eret_instr", instr_d, 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rnd",
           ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0), rand_addr(),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 14) == 0), rand_addr());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
